// File: rtl/pu_riscv_bp_ctrl_if.sv
// Branch-prediction table write-side interface.
// Bundles the branch-unit update channel and the registered RAM write port
// driven by pu_riscv_bp_ctrl. The controller uses the slave modport; the
// branch unit / RAM side (or a testbench) uses the master modport.
interface pu_riscv_bp_ctrl_if #(
    parameter int ADR_BITS = 12
) ();
    // branch-unit update request channel
    logic                upd_valid_i;
    logic [ADR_BITS-1:0] upd_adr_i;
    logic [1:0]          upd_data_i;
    logic                upd_ready_o;

    // RAM write port (registered in the controller)
    logic                ram_we_o;
    logic [ADR_BITS-1:0] ram_waddr_o;
    logic [1:0]          ram_wdata_o;

    modport master (
        output upd_valid_i,
        output upd_adr_i,
        output upd_data_i,
        input  upd_ready_o,
        input  ram_we_o,
        input  ram_waddr_o,
        input  ram_wdata_o
    );

    modport slave (
        input  upd_valid_i,
        input  upd_adr_i,
        input  upd_data_i,
        output upd_ready_o,
        output ram_we_o,
        output ram_waddr_o,
        output ram_wdata_o
    );
endinterface

// File: rtl/pu_riscv_bp_ctrl.sv
// pu_riscv_bp_ctrl: write-port controller for the correlating branch-prediction
// table (1R1W RAM of 2-bit counters).
// After reset and on every flush the whole table is walked and written with
// INIT_VALUE; once the walk has finished, branch-unit updates are forwarded to
// the RAM write port with one cycle of latency. Updates that arrive while the
// controller is not ready are dropped (the branch unit never stalls).
// Optional feature macro: PU_RISCV_BP_STATS_EN adds saturating counters of
// accepted and dropped updates; without it cnt_upd_o/cnt_drop_o are tied to 0.
module pu_riscv_bp_ctrl #(
    parameter int         BP_GLOBAL_BITS = 2,
    parameter int         BP_LOCAL_BITS  = 10,
    parameter logic [1:0] INIT_VALUE     = 2'b01
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    pu_riscv_bp_ctrl_if.slave    bp_if,
    output logic                 busy_o,
    output logic                 table_valid_o,
    output logic [31:0]          cnt_upd_o,
    output logic [31:0]          cnt_drop_o
);

    localparam int ADR_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam logic [ADR_BITS-1:0] CNT_LAST = {ADR_BITS{1'b1}};
    localparam logic [ADR_BITS-1:0] CNT_ONE  = {{(ADR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADR_BITS-1:0] CNT_ZERO = {ADR_BITS{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADR_BITS-1:0] cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADR_BITS-1:0] waddr_q, waddr_d;
    logic [1:0]          wdata_q, wdata_d;
    logic                busy_q, busy_d;

    logic                upd_ready_s;
    logic                upd_acc_s;

    // Updates are only taken once the table is fully initialised and no flush is pending.
    assign upd_ready_s = (state_q == ST_IDLE) & ~flush_i & ~busy_q;
    assign upd_acc_s   = bp_if.upd_valid_i & upd_ready_s;

    // Next-state logic: table walk in INIT, update forwarding in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        case (state_q)
            ST_INIT: begin
                // every walk cycle writes the current entry, even the one a flush restarts from
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = INIT_VALUE;
                busy_d  = 1'b1;
                if (flush_i) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_INIT;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b1;
                end else begin
                    // busy drops one edge after the last walk write was presented
                    busy_d = 1'b0;
                    if (upd_acc_s) begin
                        we_d    = 1'b1;
                        waddr_d = bp_if.upd_adr_i;
                        wdata_d = bp_if.upd_data_i;
                    end else begin
                        we_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b1;
            end
        endcase
    end

    // State, walk counter and registered RAM write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_ZERO;
            we_q    <= 1'b0;
            waddr_q <= CNT_ZERO;
            wdata_q <= 2'b00;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign bp_if.upd_ready_o = upd_ready_s;
    assign bp_if.ram_we_o    = we_q;
    assign bp_if.ram_waddr_o = waddr_q;
    assign bp_if.ram_wdata_o = wdata_q;
    assign busy_o            = busy_q;
    assign table_valid_o     = ~busy_q;

`ifdef PU_RISCV_BP_STATS_EN
    logic [31:0] cnt_upd_q, cnt_upd_d;
    logic [31:0] cnt_drop_q, cnt_drop_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Statistics: count accepted and dropped update requests, saturating.
    always_comb begin
        cnt_upd_d  = cnt_upd_q;
        cnt_drop_d = cnt_drop_q;
        if (bp_if.upd_valid_i) begin
            if (upd_ready_s) begin
                cnt_upd_d = sat_inc(cnt_upd_q);
            end else begin
                cnt_drop_d = sat_inc(cnt_drop_q);
            end
        end else begin
            cnt_upd_d  = cnt_upd_q;
            cnt_drop_d = cnt_drop_q;
        end
    end

    // Statistics registers; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_upd_q  <= 32'd0;
            cnt_drop_q <= 32'd0;
        end else begin
            cnt_upd_q  <= cnt_upd_d;
            cnt_drop_q <= cnt_drop_d;
        end
    end

    assign cnt_upd_o  = cnt_upd_q;
    assign cnt_drop_o = cnt_drop_q;
`else
    assign cnt_upd_o  = 32'd0;
    assign cnt_drop_o = 32'd0;
`endif

endmodule

// File: tb/tb_pu_riscv_bp_ctrl.sv
// Testbench for pu_riscv_bp_ctrl (DEPTH=16). A behavioural model tracks the
// walk position and expected write port; a compare process checks every
// negative clock edge. Directed sections pin the model with literal values,
// then a randomized section exercises updates, flushes and resets.
module tb_pu_riscv_bp_ctrl;

    localparam int ADR = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy, tvalid;
    logic [31:0] cnt_upd, cnt_drop;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    pu_riscv_bp_ctrl_if #(.ADR_BITS(ADR)) bp_if ();

    pu_riscv_bp_ctrl #(
        .BP_GLOBAL_BITS(2),
        .BP_LOCAL_BITS (2),
        .INIT_VALUE    (2'b01)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .bp_if        (bp_if),
        .busy_o       (busy),
        .table_valid_o(tvalid),
        .cnt_upd_o    (cnt_upd),
        .cnt_drop_o   (cnt_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos: index of the next table entry the walk writes, -1 when not walking
    int          m_pos;
    logic        m_busy, m_we;
    logic [3:0]  m_addr;
    logic [1:0]  m_data;
    logic [31:0] m_cu, m_cd;
    wire         m_ready = (m_pos < 0) && !m_busy && !flush;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  <= 0;
            m_busy <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= 4'd0;
            m_data <= 2'd0;
            m_cu   <= 32'd0;
            m_cd   <= 32'd0;
        end else begin
            if (bp_if.upd_valid_i) begin
                if (m_ready) m_cu <= m_cu + 32'd1;
                else         m_cd <= m_cd + 32'd1;
            end
            if (m_pos >= 0) begin
                m_we   <= 1'b1;
                m_addr <= m_pos[3:0];
                m_data <= 2'b01;
                m_busy <= 1'b1;
                if (flush)           m_pos <= 0;
                else if (m_pos == 15) m_pos <= -1;
                else                 m_pos <= m_pos + 1;
            end else if (flush) begin
                m_pos  <= 0;
                m_busy <= 1'b1;
                m_we   <= 1'b0;
            end else begin
                m_busy <= 1'b0;
                if (bp_if.upd_valid_i && m_ready) begin
                    m_we   <= 1'b1;
                    m_addr <= bp_if.upd_adr_i;
                    m_data <= bp_if.upd_data_i;
                end else begin
                    m_we <= 1'b0;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_we",      bp_if.ram_we_o,    m_we);
            chk("ram_waddr",   bp_if.ram_waddr_o, m_addr);
            chk("ram_wdata",   bp_if.ram_wdata_o, m_data);
            chk("busy",        busy,              m_busy);
            chk("table_valid", tvalid,            !m_busy);
            chk("upd_ready",   bp_if.upd_ready_o, m_ready);
`ifdef PU_RISCV_BP_STATS_EN
            chk("cnt_upd",     cnt_upd,           m_cu);
            chk("cnt_drop",    cnt_drop,          m_cd);
`else
            chk("cnt_upd",     cnt_upd,           32'd0);
            chk("cnt_drop",    cnt_drop,          32'd0);
`endif
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] drop_base;
    int          waited;

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        bp_if.upd_valid_i  = 1'b0;
        bp_if.upd_adr_i    = 4'd0;
        bp_if.upd_data_i   = 2'd0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        // reset state
        chk("rst_we",     bp_if.ram_we_o,    1'b0);
        chk("rst_waddr",  bp_if.ram_waddr_o, 4'd0);
        chk("rst_busy",   busy,              1'b1);
        chk("rst_tvalid", tvalid,            1'b0);

        // 1. walk after reset release
        drive_edge();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            next_neg();
            chk("walk_we",   bp_if.ram_we_o,    1'b1);
            chk("walk_addr", bp_if.ram_waddr_o, i[3:0]);
            chk("walk_data", bp_if.ram_wdata_o, 2'b01);
            chk("walk_busy", busy,              1'b1);
        end
        next_neg();
        chk("done_busy",   busy,           1'b0);
        chk("done_tvalid", tvalid,         1'b1);
        chk("done_we",     bp_if.ram_we_o, 1'b0);

        // 2. single update
        drive_edge();
        bp_if.upd_valid_i = 1'b1;
        bp_if.upd_adr_i   = 4'hA;
        bp_if.upd_data_i  = 2'b11;
        @(negedge clk);
        chk("upd_ready", bp_if.upd_ready_o, 1'b1);
        drive_edge();
        bp_if.upd_valid_i = 1'b0;
        @(negedge clk);
        chk("upd_we",    bp_if.ram_we_o,    1'b1);
        chk("upd_waddr", bp_if.ram_waddr_o, 4'hA);
        chk("upd_wdata", bp_if.ram_wdata_o, 2'b11);
        next_neg();
        chk("upd_we_off", bp_if.ram_we_o, 1'b0);

        // 3. flush in IDLE with a simultaneous update
        drive_edge();
        flush             = 1'b1;
        bp_if.upd_valid_i = 1'b1;
        bp_if.upd_adr_i   = 4'h3;
        bp_if.upd_data_i  = 2'b10;
        @(negedge clk);
        chk("flush_ready", bp_if.upd_ready_o, 1'b0);
        drive_edge();
        flush             = 1'b0;
        bp_if.upd_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy,           1'b1);
        chk("flush_we",   bp_if.ram_we_o, 1'b0);
`ifdef PU_RISCV_BP_STATS_EN
        chk("flush_drop", cnt_drop, 32'd1);
`endif
        // 4. walk restarts at 0; flush again while cnt=9
        for (int i = 0; i < 8; i++) begin
            next_neg();
            chk("rewalk_addr", bp_if.ram_waddr_o, i[3:0]);
            chk("rewalk_we",   bp_if.ram_we_o,    1'b1);
        end
        drive_edge();
        flush = 1'b1;
        @(negedge clk);
        chk("pre9_addr", bp_if.ram_waddr_o, 4'd8);
        drive_edge();
        flush = 1'b0;
        @(negedge clk);
        chk("at9_addr", bp_if.ram_waddr_o, 4'd9);
        for (int i = 0; i < 16; i++) begin
            next_neg();
            chk("restart_addr", bp_if.ram_waddr_o, i[3:0]);
            chk("restart_busy", busy,              1'b1);
        end
        next_neg();
        chk("restart_done", busy, 1'b0);

        // 5. updates held valid through a whole walk
        drop_base = cnt_drop;
        drive_edge();
        flush             = 1'b1;
        bp_if.upd_valid_i = 1'b1;
        bp_if.upd_adr_i   = 4'h6;
        bp_if.upd_data_i  = 2'b10;
        drive_edge();
        flush = 1'b0;
        repeat (17) begin
            @(negedge clk);
            chk("held_ready", bp_if.upd_ready_o, 1'b0);
            chk("held_data",  bp_if.ram_wdata_o, 2'b01);
            @(posedge clk);
        end
        #2;
        bp_if.upd_valid_i = 1'b0;
        @(negedge clk);
`ifdef PU_RISCV_BP_STATS_EN
        chk("held_drops", cnt_drop - drop_base, 32'd18);
`endif
        chk("held_tvalid", tvalid, 1'b1);

        // 6. reset mid-walk at cnt=5
        drive_edge();
        flush = 1'b1;
        drive_edge();
        flush = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we",    bp_if.ram_we_o,    1'b0);
        chk("mid_rst_waddr", bp_if.ram_waddr_o, 4'd0);
        chk("mid_rst_wdata", bp_if.ram_wdata_o, 2'd0);
        chk("mid_rst_busy",  busy,              1'b1);
        chk("mid_rst_cnt",   cnt_drop,          32'd0);
        drive_edge();
        rst = 1'b0;
        next_neg();
        chk("post_rst_addr0", bp_if.ram_waddr_o, 4'd0);
        next_neg();
        chk("post_rst_addr1", bp_if.ram_waddr_o, 4'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            rst               = ($urandom_range(0, 299) == 0);
            flush             = ($urandom_range(0, 59) == 0);
            bp_if.upd_valid_i = $urandom_range(0, 1) == 1;
            bp_if.upd_adr_i   = 4'($urandom_range(0, 15));
            bp_if.upd_data_i  = 2'($urandom_range(0, 3));
        end
        drive_edge();
        rst               = 1'b0;
        flush             = 1'b0;
        bp_if.upd_valid_i = 1'b0;

        // bounded wait for the table to become valid
        waited = 0;
        while (busy && waited < 40) begin
            next_neg();
            waited++;
        end
        chk("final_idle", busy, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
